spi_controller: RTL and testbench

//   SPI mode-0 controller (initiator) for the onboarding SPI peripheral register map.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_controller_if.sv | 23 ++
 rtl/spi_half_tick.sv | 28 ++
 rtl/spi_controller.sv | 117 +++++++++++
 tb/tb_spi_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI register-map controller.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;

    localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
    localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
    localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
    localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY  = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } spi_state_t;

endpackage

// File: rtl/spi_controller_if.sv
// Request/response handshake between a host and the SPI controller.
interface spi_controller_if;
    import spi_pkg::*;

    logic                  start;
    logic                  tx_rw;
    logic [6:0]            tx_addr;
    logic [7:0]            tx_data;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_frame;

    modport master (
        output start, tx_rw, tx_addr, tx_data,
        input  busy, done, rx_frame
    );

    modport slave (
        input  start, tx_rw, tx_addr, tx_data,
        output busy, done, rx_frame
    );

endinterface

// File: rtl/spi_half_tick.sv
// Enable-gated divider: one-cycle tick every CLK_DIV clocks while enabled.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one {rw, addr, data} frame per request, MSB first,
// with CIPO captured into rx_frame at the end of the frame.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus,
    output logic             sclk,
    output logic             copi,
    output logic             ncs,
    input  logic             cipo
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [4:0] ALL_BITS = 5'(FRAME_BITS);

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_frame;
    logic [4:0]            r_bit_cnt;
    logic                  r_sclk;
    logic                  r_copi;
    logic                  r_ncs;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tick;
    logic                  w_tick_en;

    // The divider runs only while a frame is in flight so every phase starts aligned.
    assign w_tick_en = (r_state != ST_IDLE);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_frame <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_copi     <= 1'b0;
            r_ncs      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_tx_shift <= {bus.tx_rw, bus.tx_addr, bus.tx_data};
                        r_copi     <= bus.tx_rw;
                        r_ncs      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_sclk     <= 1'b1;
                        r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], cipo};
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_sclk) begin
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            // Bit 0 stays on COPI through its low phase, which is also the CS hold.
                            if (r_bit_cnt != LAST_BIT) begin
                                r_tx_shift <= r_tx_shift << 1;
                                r_copi     <= r_tx_shift[RW_BIT-1];
                            end
                        end else if (r_bit_cnt == ALL_BITS) begin
                            r_ncs      <= 1'b1;
                            r_copi     <= 1'b0;
                            r_done     <= 1'b1;
                            r_rx_frame <= r_rx_shift;
                            r_state    <= ST_GAP;
                        end else begin
                            r_sclk     <= 1'b1;
                            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], cipo};
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sclk         = r_sclk;
    assign copi         = r_copi;
    assign ncs          = r_ncs;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rx_frame = r_rx_frame;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a CLK_DIV=2 instance for the main scenarios
// and a CLK_DIV=1 instance for the fastest divider.
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sclk_a, copi_a, ncs_a, cipo_a, cipo_a_val, loop_a;
    logic sclk_b, copi_b, ncs_b, cipo_b;

    spi_controller_if bus_a();
    spi_controller_if bus_b();

    assign cipo_a = loop_a ? copi_a : cipo_a_val;
    assign cipo_b = copi_b;

    spi_controller #(.CLK_DIV(D)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a), .cipo(cipo_a)
    );

    spi_controller #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b), .cipo(cipo_b)
    );

    typedef struct { logic [15:0] frame; int rises; int low; } frm_t;
    typedef struct { logic [15:0] frame; logic [15:0] rx; } exp_t;

    exp_t        exp_q[$];
    frm_t        obs_a[$], obs_b[$];
    int          done_cyc_a[$], done_cyc_b[$];
    logic [15:0] rx_a[$], rx_b[$];

    int total = 0, bad = 0, cyc = 0, sclk_leak = 0;
    int done_cnt_a = 0, busy_fall_a = 0, busy_rise_a = 0, ncs_rise_a = 0, ncs_fall_a = 0;
    int done_cnt_b = 0, busy_fall_b = 0, last_rise_b = 0, per_min_b = 0, per_max_b = 0;
    int rises_a = 0, low_a = 0, rises_b = 0, low_b = 0;
    logic [15:0] cap_a = '0, cap_b = '0;
    logic prev_sclk_a = 1'b0, prev_ncs_a = 1'b1, prev_busy_a = 1'b0;
    logic prev_sclk_b = 1'b0, prev_ncs_b = 1'b1, prev_busy_b = 1'b0;

    // Bus monitors: decode COPI on each SCLK rise and record frame/timing observations.
    always begin
        @(negedge clk);
        cyc++;
        if (sclk_a === 1'b1 && ncs_a === 1'b1) sclk_leak++;
        if (sclk_b === 1'b1 && ncs_b === 1'b1) sclk_leak++;
        if (ncs_a === 1'b0) begin
            if (prev_ncs_a) begin ncs_fall_a = cyc; rises_a = 0; low_a = 0; cap_a = '0; end
            low_a++;
            if (sclk_a && !prev_sclk_a) begin rises_a++; cap_a = {cap_a[14:0], copi_a}; end
        end else if (ncs_a === 1'b1 && !prev_ncs_a) begin
            ncs_rise_a = cyc;
            obs_a.push_back('{cap_a, rises_a, low_a});
        end
        if (bus_a.done === 1'b1) begin done_cnt_a++; done_cyc_a.push_back(cyc); rx_a.push_back(bus_a.rx_frame); end
        if (prev_busy_a === 1'b1 && bus_a.busy === 1'b0) busy_fall_a = cyc;
        if (prev_busy_a === 1'b0 && bus_a.busy === 1'b1) busy_rise_a = cyc;
        if (ncs_b === 1'b0) begin
            if (prev_ncs_b) begin rises_b = 0; low_b = 0; cap_b = '0; per_min_b = 999; per_max_b = 0; end
            low_b++;
            if (sclk_b && !prev_sclk_b) begin
                if (rises_b > 0) begin
                    if (cyc - last_rise_b < per_min_b) per_min_b = cyc - last_rise_b;
                    if (cyc - last_rise_b > per_max_b) per_max_b = cyc - last_rise_b;
                end
                last_rise_b = cyc;
                rises_b++;
                cap_b = {cap_b[14:0], copi_b};
            end
        end else if (ncs_b === 1'b1 && !prev_ncs_b) begin
            obs_b.push_back('{cap_b, rises_b, low_b});
        end
        if (bus_b.done === 1'b1) begin done_cnt_b++; done_cyc_b.push_back(cyc); rx_b.push_back(bus_b.rx_frame); end
        if (prev_busy_b === 1'b1 && bus_b.busy === 1'b0) busy_fall_b = cyc;
        prev_sclk_a = sclk_a; prev_ncs_a = ncs_a; prev_busy_a = bus_a.busy;
        prev_sclk_b = sclk_b; prev_ncs_b = ncs_b; prev_busy_b = bus_b.busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_a(input logic rw, input logic [6:0] addr, input logic [7:0] data, output int sc);
        bus_a.tx_rw = rw; bus_a.tx_addr = addr; bus_a.tx_data = data; bus_a.start = 1'b1;
        sc = cyc;
        tick();
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output bit ok);
        for (int i = 0; i < budget && done_cyc_a.size() == 0; i++) tick();
        ok = (done_cyc_a.size() != 0);
    endtask

    task automatic wait_idle_a(input int budget);
        for (int i = 0; i < budget && bus_a.busy !== 1'b0; i++) tick();
    endtask

    task automatic pop_a(output frm_t f, output logic [15:0] rx, output int dc);
        f = '{16'hxxxx, -1, -1}; rx = 'x; dc = -1;
        if (obs_a.size() != 0) f = obs_a.pop_front();
        if (rx_a.size() != 0) rx = rx_a.pop_front();
        if (done_cyc_a.size() != 0) dc = done_cyc_a.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; loop_a = 1'b0; cipo_a_val = 1'b0;
        bus_a.start = 1'b0; bus_a.tx_rw = 1'b0; bus_a.tx_addr = '0; bus_a.tx_data = '0;
        bus_b.start = 1'b0; bus_b.tx_rw = 1'b0; bus_b.tx_addr = '0; bus_b.tx_data = '0;
        repeat (3) tick();
        total++; if (ncs_a !== 1'b1) begin bad++; $display("FAIL reset_ncs got=%b want=1", ncs_a); end
        total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk_a); end
        total++; if (copi_a !== 1'b0) begin bad++; $display("FAIL reset_copi got=%b want=0", copi_a); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
        total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
        total++; if (bus_a.rx_frame !== 16'h0000) begin bad++; $display("FAIL reset_rx got=%h want=0000", bus_a.rx_frame); end
        total++; if (ncs_b !== 1'b1 || bus_b.busy !== 1'b0) begin bad++; $display("FAIL reset_b got ncs=%b busy=%b want 1/0", ncs_b, bus_b.busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int sc, dc, d0; bit ok; frm_t f; logic [15:0] rx; exp_t e;
        d0 = done_cnt_a;
        exp_q.push_back('{16'h8480, 16'h0000});
        send_a(1'b1, REG_PWM_DUTY, 8'h80, sc);
        wait_done_a(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL write_timeout got=no_done want=done"); end
        wait_idle_a(50);
        pop_a(f, rx, dc);
        e = exp_q.pop_front();
        total++; if (f.frame !== e.frame) begin bad++; $display("FAIL write_frame got=%h want=%h", f.frame, e.frame); end
        total++; if (f.rises !== 16) begin bad++; $display("FAIL write_rises got=%0d want=16", f.rises); end
        total++; if (f.low !== 33*D) begin bad++; $display("FAIL write_ncs_low got=%0d want=%0d", f.low, 33*D); end
        total++; if (dc - sc !== 33*D+1) begin bad++; $display("FAIL write_latency got=%0d want=%0d", dc - sc, 33*D+1); end
        total++; if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL write_done_cycles got=%0d want=1", done_cnt_a - d0); end
        total++; if (rx !== e.rx) begin bad++; $display("FAIL write_rx got=%h want=%h", rx, e.rx); end
        total++; if (busy_fall_a - dc !== D) begin bad++; $display("FAIL write_busy_tail got=%0d want=%0d", busy_fall_a - dc, D); end
    endtask

    task automatic test_loopback();
        int sc, dc; bit ok; frm_t f; logic [15:0] rx; exp_t e;
        loop_a = 1'b1;
        exp_q.push_back('{16'h02A5, 16'h02A5});
        send_a(1'b0, REG_EN_PWM_LO, 8'hA5, sc);
        wait_done_a(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL loop_timeout got=no_done want=done"); end
        total++; if (bus_a.rx_frame !== 16'h02A5) begin bad++; $display("FAIL loop_rx_at_done got=%h want=02A5", bus_a.rx_frame); end
        wait_idle_a(50);
        pop_a(f, rx, dc);
        e = exp_q.pop_front();
        total++; if (f.frame !== e.frame) begin bad++; $display("FAIL loop_frame got=%h want=%h", f.frame, e.frame); end
        total++; if (rx !== e.rx) begin bad++; $display("FAIL loop_rx got=%h want=%h", rx, e.rx); end
        total++; if (busy_fall_a - dc !== D) begin bad++; $display("FAIL loop_busy_tail got=%0d want=%0d", busy_fall_a - dc, D); end
        loop_a = 1'b0;
    endtask

    task automatic test_ignore_start();
        int sc, dc, d0, n0; bit ok; frm_t f; logic [15:0] rx; exp_t e;
        cipo_a_val = 1'b1;
        d0 = done_cnt_a; n0 = obs_a.size();
        exp_q.push_back('{16'h1234, 16'hFFFF});
        send_a(1'b0, 7'h12, 8'h34, sc);
        repeat (20) tick();
        bus_a.tx_rw = 1'b1; bus_a.tx_addr = 7'h7F; bus_a.tx_data = 8'h00; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_done_a(300, ok);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL ignore_timeout got=no_done want=done"); end
        repeat (80) tick();
        total++; if (obs_a.size() - n0 !== 1) begin bad++; $display("FAIL ignore_frames got=%0d want=1", obs_a.size() - n0); end
        total++; if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL ignore_dones got=%0d want=1", done_cnt_a - d0); end
        pop_a(f, rx, dc);
        e = exp_q.pop_front();
        total++; if (f.frame !== e.frame) begin bad++; $display("FAIL ignore_frame got=%h want=%h", f.frame, e.frame); end
        total++; if (rx !== e.rx) begin bad++; $display("FAIL ignore_rx got=%h want=%h", rx, e.rx); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b want=0", bus_a.busy); end
        while (obs_a.size() > 0) void'(obs_a.pop_front());
        cipo_a_val = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sc, dc1, dc2; bit ok; frm_t f1, f2; logic [15:0] rx1, rx2; exp_t e;
        exp_q.push_back('{16'h815A, 16'h0000});
        exp_q.push_back('{16'h815A, 16'h0000});
        bus_a.tx_rw = 1'b1; bus_a.tx_addr = REG_EN_OUT_HI; bus_a.tx_data = 8'h5A; bus_a.start = 1'b1;
        sc = cyc;
        wait_done_a(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout1 got=no_done want=done"); end
        pop_a(f1, rx1, dc1);
        wait_idle_a(50);
        for (int i = 0; i < 50 && bus_a.busy !== 1'b1; i++) tick();
        bus_a.start = 1'b0;
        total++; if ((busy_rise_a - 1) - sc !== 34*D+1) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", (busy_rise_a - 1) - sc, 34*D+1); end
        total++; if (ncs_fall_a - ncs_rise_a !== D+1) begin bad++; $display("FAIL b2b_ncs_high got=%0d want=%0d", ncs_fall_a - ncs_rise_a, D+1); end
        wait_done_a(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout2 got=no_done want=done"); end
        pop_a(f2, rx2, dc2);
        e = exp_q.pop_front();
        total++; if (f1.frame !== e.frame) begin bad++; $display("FAIL b2b_frame1 got=%h want=%h", f1.frame, e.frame); end
        e = exp_q.pop_front();
        total++; if (f2.frame !== e.frame || f2.rises !== 16) begin bad++; $display("FAIL b2b_frame2 got=%h/%0d want=%h/16", f2.frame, f2.rises, e.frame); end
        total++; if (dc2 - dc1 !== 34*D+1) begin bad++; $display("FAIL b2b_done_spacing got=%0d want=%0d", dc2 - dc1, 34*D+1); end
        repeat (2*D+10) tick();
        total++; if (bus_a.busy !== 1'b0 || obs_a.size() !== 0) begin bad++; $display("FAIL b2b_no_third got busy=%b frames=%0d want 0/0", bus_a.busy, obs_a.size()); end
    endtask

    task automatic test_reset_mid();
        int sc, d0, dc; bit ok; frm_t f; logic [15:0] rx; exp_t e;
        d0 = done_cnt_a;
        send_a(1'b1, REG_EN_PWM_HI, 8'h0F, sc);
        for (int i = 0; i < 200 && !(ncs_a === 1'b0 && rises_a == 5); i++) tick();
        rst_n = 1'b0;
        tick();
        total++; if (ncs_a !== 1'b1 || sclk_a !== 1'b0 || bus_a.busy !== 1'b0) begin bad++; $display("FAIL abort_outputs got ncs=%b sclk=%b busy=%b want 1/0/0", ncs_a, sclk_a, bus_a.busy); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (done_cnt_a !== d0 || done_cyc_a.size() !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt_a - d0); end
        f = '{16'hxxxx, -1, -1};
        if (obs_a.size() != 0) f = obs_a.pop_front();
        total++; if (f.rises !== 5) begin bad++; $display("FAIL abort_rises got=%0d want=5", f.rises); end
        cipo_a_val = 1'b1;
        exp_q.push_back('{16'h043C, 16'hFFFF});
        send_a(1'b0, REG_PWM_DUTY, 8'h3C, sc);
        wait_done_a(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL after_abort_timeout got=no_done want=done"); end
        wait_idle_a(50);
        pop_a(f, rx, dc);
        e = exp_q.pop_front();
        total++; if (f.frame !== e.frame || f.rises !== 16 || f.low !== 33*D) begin bad++; $display("FAIL after_abort_frame got=%h/%0d/%0d want=%h/16/%0d", f.frame, f.rises, f.low, e.frame, 33*D); end
        total++; if (rx !== e.rx) begin bad++; $display("FAIL after_abort_rx got=%h want=%h", rx, e.rx); end
        cipo_a_val = 1'b0;
    endtask

    task automatic test_clkdiv1();
        int sc, dc; frm_t f; logic [15:0] rx; exp_t e;
        exp_q.push_back('{16'h80FF, 16'h80FF});
        bus_b.tx_rw = 1'b1; bus_b.tx_addr = REG_EN_OUT_LO; bus_b.tx_data = 8'hFF; bus_b.start = 1'b1;
        sc = cyc;
        tick();
        bus_b.start = 1'b0;
        for (int i = 0; i < 200 && done_cyc_b.size() == 0; i++) tick();
        total++; if (done_cyc_b.size() == 0) begin bad++; $display("FAIL div1_timeout got=no_done want=done"); end
        for (int i = 0; i < 50 && bus_b.busy !== 1'b0; i++) tick();
        f = '{16'hxxxx, -1, -1}; rx = 'x; dc = -1;
        if (obs_b.size() != 0) f = obs_b.pop_front();
        if (rx_b.size() != 0) rx = rx_b.pop_front();
        if (done_cyc_b.size() != 0) dc = done_cyc_b.pop_front();
        e = exp_q.pop_front();
        total++; if (f.frame !== e.frame || f.rises !== 16) begin bad++; $display("FAIL div1_frame got=%h/%0d want=%h/16", f.frame, f.rises, e.frame); end
        total++; if (f.low !== 33) begin bad++; $display("FAIL div1_ncs_low got=%0d want=33", f.low); end
        total++; if (per_min_b !== 2 || per_max_b !== 2) begin bad++; $display("FAIL div1_sclk_period got=%0d..%0d want=2", per_min_b, per_max_b); end
        total++; if (dc - sc !== 34) begin bad++; $display("FAIL div1_latency got=%0d want=34", dc - sc); end
        total++; if (rx !== e.rx) begin bad++; $display("FAIL div1_rx got=%h want=%h", rx, e.rx); end
        total++; if (busy_fall_b - dc !== 1 || done_cnt_b !== 1) begin bad++; $display("FAIL div1_tail got=%0d/%0d want=1/1", busy_fall_b - dc, done_cnt_b); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_loopback();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        total++; if (sclk_leak !== 0) begin bad++; $display("FAIL sclk_while_ncs_high got=%0d want=0", sclk_leak); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
